// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences one byte-wide RAM port between instruction fetch (IF)
// and the load/store stage (ME). Each 1/2/4-byte access is serialized into
// per-byte RAM cycles; read data is assembled little-endian.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   if_req/if_addr      IF word-fetch request (held until if_done)
//   if_data/if_done     fetched word and one-cycle completion pulse
//   me_req/me_we/me_len/me_addr/me_wdata  ME load/store request
//   me_rdata/me_done    load data (zero-filled above length) and done pulse
//   me_misalign         misalignment flag, valid with me_done
//   stall_req_from_if/me  stall requests while an access is outstanding
//   ram_addr/ram_din/ram_dout/ram_wr  RAM port (read latency 1 cycle)
//
// Optional build macro: MEM_ARB_MISALIGN_CHK_EN -- when defined, misaligned
// half/word ME accesses complete immediately with me_misalign=1 and no RAM
// traffic; when undefined they are performed bytewise and me_misalign is 0.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              me_req,
  input  logic              me_we,
  input  logic [1:0]        me_len,
  input  logic [31:0]       me_addr,
  input  logic [31:0]       me_wdata,
  output logic [31:0]       me_rdata,
  output logic              me_done,
  output logic              me_misalign,
  output logic              stall_req_from_if,
  output logic              stall_req_from_me,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         n_q, n_d;
  logic [2:0]         me_n;
  logic               own_me_q, own_me_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  addr_sum;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        data_q, data_d;
  logic               done_if, done_me;

  // Upper address bits lie outside the RAM and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr[31:ADDR_W], me_addr[31:ADDR_W]};

`ifdef MEM_ARB_MISALIGN_CHK_EN
  logic mis_q, mis_d;
  logic me_misal_req;
  assign me_misal_req = ((me_len == 2'b01) && me_addr[0]) ||
                        (me_len[1] && (me_addr[1:0] != 2'b00));
`endif

  // Reserved length 11 behaves as a word access.
  always_comb begin
    case (me_len)
      2'b00:   me_n = 3'd1;
      2'b01:   me_n = 3'd2;
      default: me_n = 3'd4;
    endcase
  end

  // Truncation to ADDR_W bits gives the wrap past the top of RAM.
  assign addr_sum = base_q + {{(ADDR_W-3){1'b0}}, cnt_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    own_me_d = own_me_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
`ifdef MEM_ARB_MISALIGN_CHK_EN
    mis_d    = mis_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef MEM_ARB_MISALIGN_CHK_EN
        mis_d = 1'b0;
`endif
        if (me_req) begin
          own_me_d = 1'b1;
          base_d   = me_addr[ADDR_W-1:0];
          n_d      = me_n;
          wdata_d  = me_wdata;
          data_d   = '0;
          state_d  = me_we ? WR : RD;
`ifdef MEM_ARB_MISALIGN_CHK_EN
          if (me_misal_req) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end else if (if_req) begin
          own_me_d = 1'b0;
          base_d   = if_addr[ADDR_W-1:0];
          n_d      = 3'd4;
          data_d   = '0;
          state_d  = RD;
        end
      end
      RD: begin
        // Byte requested at cnt-1 arrives now (one-cycle RAM latency).
        for (int unsigned i = 0; i < 4; i++) begin
          if (cnt_q == 3'(i + 1)) data_d[8*i +: 8] = ram_din;
        end
        if (cnt_q == n_q) state_d = DONE;
        else              cnt_d   = cnt_q + 3'd1;
      end
      WR: begin
        if (cnt_q == n_q - 3'd1) state_d = DONE;
        else                     cnt_d   = cnt_q + 3'd1;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      own_me_q <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
`ifdef MEM_ARB_MISALIGN_CHK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      own_me_q <= own_me_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
`ifdef MEM_ARB_MISALIGN_CHK_EN
      mis_q    <= mis_d;
`endif
    end
  end

  // RAM port decoded from registered state only, so reset clears ram_wr at once.
  always_comb begin
    ram_addr = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    case (state_q)
      RD: if (cnt_q < n_q) ram_addr = addr_sum;
      WR: begin
        ram_wr   = 1'b1;
        ram_addr = addr_sum;
        for (int unsigned i = 0; i < 4; i++) begin
          if (cnt_q[1:0] == 2'(i)) ram_dout = wdata_q[8*i +: 8];
        end
      end
      default: ;
    endcase
  end

  assign done_if = (state_q == DONE) && !own_me_q;
  assign done_me = (state_q == DONE) &&  own_me_q;

  assign if_done  = done_if;
  assign me_done  = done_me;
  assign if_data  = done_if ? data_q : '0;
  assign me_rdata = done_me ? data_q : '0;

  assign stall_req_from_if = if_req & ~done_if;
  assign stall_req_from_me = me_req & ~done_me;

`ifdef MEM_ARB_MISALIGN_CHK_EN
  assign me_misalign = done_me & mis_q;
`else
  assign me_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-requester transactions plus
// hand-written sequences for arbitration, address wrap, store bus timing and
// reset during a store. Uses a bench-side byte RAM with one-cycle read latency.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              me_req;
  logic              me_we;
  logic [1:0]        me_len;
  logic [31:0]       me_addr;
  logic [31:0]       me_wdata;
  logic [31:0]       me_rdata;
  logic              me_done;
  logic              me_misalign;
  logic              stall_req_from_if;
  logic              stall_req_from_me;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic              ram_wr;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .me_req(me_req), .me_we(me_we), .me_len(me_len), .me_addr(me_addr),
    .me_wdata(me_wdata), .me_rdata(me_rdata), .me_done(me_done),
    .me_misalign(me_misalign),
    .stall_req_from_if(stall_req_from_if), .stall_req_from_me(stall_req_from_me),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // Bench RAM: preload happens only while 'preload' is set.
  logic [7:0] ram [0:(1<<ADDR_W)-1];
  logic       preload;

  always @(posedge clk) begin
    if (preload) begin
      ram[17'h00100] <= 8'h11; ram[17'h00101] <= 8'h22;
      ram[17'h00102] <= 8'h33; ram[17'h00103] <= 8'h44;
      ram[17'h00104] <= 8'h00; ram[17'h00105] <= 8'h00;
      ram[17'h00300] <= 8'h80;
      ram[17'h00201] <= 8'h5A; ram[17'h00202] <= 8'hC3;
      ram[17'h1FFFF] <= 8'hA1; ram[17'h00000] <= 8'hB2;
      ram[17'h00001] <= 8'hC3; ram[17'h00002] <= 8'hD4;
    end else if (ram_wr) begin
      ram[ram_addr] <= ram_dout;
    end
    ram_din <= ram[ram_addr];
  end

  typedef struct {
    logic        is_me;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_cyc;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one single-requester transaction; req rises in cycle 0.
  task automatic run_vec(input int idx, input vec_t v);
    int          dc = -1;
    logic [31:0] dd = '0;
    logic        dm = 1'b0;
    logic        wr_seen = 1'b0;
    if (v.is_me) begin
      me_req = 1'b1; me_we = v.we; me_len = v.len;
      me_addr = v.addr; me_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ram_wr) wr_seen = 1'b1;
      if (dc < 0 && v.is_me && me_done) begin
        dc = c; dd = me_rdata; dm = me_misalign;
      end
      if (dc < 0 && !v.is_me && if_done) begin
        dc = c; dd = if_data;
      end
      @(posedge clk); #1;
      if (dc >= 0) begin
        me_req = 1'b0; if_req = 1'b0;
        break;
      end
    end
    chk($sformatf("vec%0d done_cycle", idx), dc, v.exp_cyc);
    if (v.chk_data) chk($sformatf("vec%0d data", idx), dd, v.exp_data);
    if (v.is_me) chk($sformatf("vec%0d misalign", idx), {31'd0, dm}, {31'd0, v.exp_mis});
    if (!v.we) chk($sformatf("vec%0d no_ram_wr", idx), {31'd0, wr_seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            me  we  len    addr           wdata         cyc chk data           mis
    vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        6, 1'b1, 32'h4433_2211, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        6, 1'b1, 32'h4433_2211, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0300, 32'h0,        3, 1'b1, 32'h0000_0080, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0,        4, 1'b1, 32'h0000_4433, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0100, 32'h0,        6, 1'b1, 32'h4433_2211, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0103, 32'h0,        3, 1'b1, 32'h0000_0044, 1'b0};
`ifdef MEM_ARB_MISALIGN_CHK_EN
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0201, 32'h0,        1, 1'b1, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'b10, 32'hFFF0_0102, 32'h0,        1, 1'b1, 32'h0000_0000, 1'b1};
`else
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0201, 32'h0,        4, 1'b1, 32'h0000_C35A, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b10, 32'hFFF0_0102, 32'h0,        6, 1'b1, 32'h0000_4433, 1'b0};
`endif
    vecs[8]  = '{1'b1, 1'b1, 2'b10, 32'h0000_0200, 32'hDEADBEEF, 5, 1'b0, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0400, 32'h12345677, 2, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0,        6, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 32'h0000_0400, 32'h0,        3, 1'b1, 32'h0000_0077, 1'b0};

    rst = 1'b1; preload = 1'b1;
    if_req = 1'b0; if_addr = '0;
    me_req = 1'b1; me_we = 1'b1; me_len = 2'b10; me_addr = 32'h200; me_wdata = '1;

    // Reset state, with a request held high: nothing may be served.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst me_done", {31'd0, me_done}, 32'd0);
      chk("rst ram_wr", {31'd0, ram_wr}, 32'd0);
    end
    chk("rst ram_addr", {15'd0, ram_addr}, 32'd0);
    chk("rst if_done", {31'd0, if_done}, 32'd0);
    chk("rst if_data", if_data, 32'd0);
    chk("rst me_rdata", me_rdata, 32'd0);
    chk("rst me_misalign", {31'd0, me_misalign}, 32'd0);
    chk("rst stall_if", {31'd0, stall_req_from_if}, 32'd0);
    me_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; preload = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Word store bus timing: bytes EF,BE,AD,DE in cycles 1-4, done in cycle 5.
    me_req = 1'b1; me_we = 1'b1; me_len = 2'b10; me_addr = 32'h200; me_wdata = 32'hDEADBEEF;
    for (int c = 0; c <= 5; c++) begin
      logic [31:0] wd;
      wd = 32'hDEADBEEF;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("st c%0d ram_wr", c), {31'd0, ram_wr}, 32'd1);
        chk($sformatf("st c%0d ram_addr", c), {15'd0, ram_addr}, 32'h200 + 32'(c - 1));
        chk($sformatf("st c%0d ram_dout", c), {24'd0, ram_dout}, {24'd0, wd[8*(c-1) +: 8]});
      end else begin
        chk($sformatf("st c%0d ram_wr", c), {31'd0, ram_wr}, 32'd0);
      end
      if (c == 4) chk("st c4 me_done", {31'd0, me_done}, 32'd0);
      if (c == 5) chk("st c5 me_done", {31'd0, me_done}, 32'd1);
      @(posedge clk); #1;
    end
    me_req = 1'b0;
    @(posedge clk); #1;

    // Address wrap at the top of a 17-bit RAM.
    me_req = 1'b1; me_we = 1'b0; me_len = 2'b10; me_addr = 32'h0001_FFFF;
    for (int c = 0; c <= 6; c++) begin
      logic [16:0] ea [4];
      ea[0] = 17'h1FFFF; ea[1] = 17'h00000; ea[2] = 17'h00001; ea[3] = 17'h00002;
      @(negedge clk);
      if (c >= 1 && c <= 4)
        chk($sformatf("wrap c%0d ram_addr", c), {15'd0, ram_addr}, {15'd0, ea[c-1]});
      if (c == 6) begin
        chk("wrap me_done", {31'd0, me_done}, 32'd1);
        chk("wrap me_rdata", me_rdata, 32'hD4C3_B2A1);
      end
      @(posedge clk); #1;
    end
    me_req = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests: ME first, IF granted in the IDLE cycle after ME's DONE.
    me_req = 1'b1; me_we = 1'b0; me_len = 2'b00; me_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 9) chk($sformatf("arb c%0d stall_if", c), {31'd0, stall_req_from_if}, 32'd1);
      if (c == 2) chk("arb c2 me_done", {31'd0, me_done}, 32'd0);
      if (c == 3) begin
        chk("arb c3 me_done", {31'd0, me_done}, 32'd1);
        chk("arb c3 me_rdata", me_rdata, 32'h0000_0080);
        chk("arb c3 stall_me", {31'd0, stall_req_from_me}, 32'd0);
      end
      if (c == 5) chk("arb c5 ram_addr", {15'd0, ram_addr}, 32'h100);
      if (c == 9) chk("arb c9 if_done", {31'd0, if_done}, 32'd0);
      if (c == 10) begin
        chk("arb c10 if_done", {31'd0, if_done}, 32'd1);
        chk("arb c10 if_data", if_data, 32'h4433_2211);
        chk("arb c10 stall_if", {31'd0, stall_req_from_if}, 32'd0);
      end
      @(posedge clk); #1;
      if (c == 3) me_req = 1'b0;
    end
    if_req = 1'b0;
    @(posedge clk); #1;

    // Reset during the 2nd WR cycle of a word store, then replay from IDLE.
    me_req = 1'b1; me_we = 1'b1; me_len = 2'b10; me_addr = 32'h500; me_wdata = 32'h0102_0304;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
    chk("rstwr pre ram_wr", {31'd0, ram_wr}, 32'd1);
    chk("rstwr pre ram_addr", {15'd0, ram_addr}, 32'h501);
    rst = 1'b1;
    #1;
    chk("rstwr async ram_wr", {31'd0, ram_wr}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rstwr hold%0d me_done", c), {31'd0, me_done}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int dc = -1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (c == 1) begin
          chk("rstwr replay ram_addr", {15'd0, ram_addr}, 32'h500);
          chk("rstwr replay ram_dout", {24'd0, ram_dout}, 32'h04);
        end
        if (me_done) dc = c;
        @(posedge clk); #1;
        if (dc >= 0) break;
      end
      chk("rstwr replay done_cycle", dc, 32'd5);
    end
    me_req = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
